// File: rtl/pwr_pkg.sv
// Shared state encoding, widths and default tuning constants for the load scheduler.
package pwr_pkg;

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_RAMP  = 3'd1,
      ST_ON    = 3'd2,
      ST_FAULT = 3'd3,
      ST_LOCK  = 3'd4
   } pwr_state_e;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_BUDGET_MA  = 500;
   localparam int DEF_SETTLE_CYC = 16;
   localparam int DEF_OC_CYC     = 8;
   localparam int DEF_COOL_CYC   = 64;
   localparam int DEF_IDLE_CYC   = 32;
   localparam int DEF_MAX_RETRY  = 3;

   localparam int MA_W    = 10;
   localparam int ALLOC_W = 11;
   localparam int CNT_W   = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/pwr_rr_pick.sv
// Combinational round-robin picker: first requester that is also eligible, searching from ptr.
module pwr_rr_pick
   import pwr_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [NUM_REQ-1:0] i_elig,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_pick
);

   logic             w_found;
   logic [PTR_W-1:0] w_idx;

   always_comb begin
      o_pick  = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
         if (!w_found && i_req[w_idx] && i_elig[w_idx]) begin
            o_pick[w_idx] = 1'b1;
            w_found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pwr_load_sched.sv
// Power-gated load scheduler: sequences the supply, grants requesters within a current
// budget, and trips to FAULT/LOCK on over-current, supply loss or a blown fuse.
module pwr_load_sched
   import pwr_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int BUDGET_MA  = DEF_BUDGET_MA,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int OC_CYC     = DEF_OC_CYC,
   parameter int COOL_CYC   = DEF_COOL_CYC,
   parameter int IDLE_CYC   = DEF_IDLE_CYC,
   parameter int MAX_RETRY  = DEF_MAX_RETRY
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0][MA_W-1:0]   req_ma,
   input  logic                           powered,
   input  logic                           fuse_blown,
   input  logic [MA_W-1:0]                meas_ma,
   input  logic                           clr_fault,
   output logic                           pwr_en,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [ALLOC_W-1:0]             alloc_ma,
   output logic [2:0]                     state,
   output logic                           fault,
   output logic                           lockout
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int RET_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [ALLOC_W-1:0] BUDGET_V    = ALLOC_W'(BUDGET_MA);
   localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0]   OC_LAST     = CNT_W'(OC_CYC - 1);
   localparam logic [CNT_W-1:0]   COOL_LAST   = CNT_W'(COOL_CYC - 1);
   localparam logic [CNT_W-1:0]   IDLE_LAST   = CNT_W'(IDLE_CYC - 1);
   localparam logic [RET_W-1:0]   RETRY_MAX   = RET_W'(MAX_RETRY);

   pwr_state_e                     r_state;
   logic                           r_pwr_en;
   logic                           r_fault;
   logic                           r_lock;
   logic [NUM_REQ-1:0]             r_gnt;
   logic [ALLOC_W-1:0]             r_alloc;
   logic [NUM_REQ-1:0][MA_W-1:0]   r_lat;
   logic [PTR_W-1:0]               r_ptr;
   logic [CNT_W-1:0]               r_cnt;
   logic [CNT_W-1:0]               r_oc_cnt;
   logic [CNT_W-1:0]               r_idle_cnt;
   logic [RET_W-1:0]               r_retry;

   pwr_state_e                     w_nxt;
   logic                           w_retry_clr;
   logic                           w_over;
   logic                           w_idle;
   logic [NUM_REQ-1:0]             w_rel;
   logic [ALLOC_W-1:0]             w_rel_sum;
   logic [NUM_REQ-1:0]             w_elig;
   logic [NUM_REQ-1:0]             w_cand;
   logic                           w_arb_en;
   logic [NUM_REQ-1:0]             w_pick;
   logic [PTR_W-1:0]               w_pick_idx;
   logic [ALLOC_W-1:0]             w_pick_amt;

   assign w_over = ALLOC_W'(meas_ma) > BUDGET_V;
   assign w_idle = ~(|req);

   always_comb begin
      w_nxt       = r_state;
      w_retry_clr = 1'b0;
      case (r_state)
         ST_OFF:   if (|req) w_nxt = ST_RAMP;
         ST_RAMP: begin
            if (fuse_blown)                w_nxt = ST_FAULT;
            else if (r_cnt == SETTLE_LAST) w_nxt = powered ? ST_ON : ST_FAULT;
         end
         ST_ON: begin
            if (fuse_blown || !powered)              w_nxt = ST_FAULT;
            else if (w_over && r_oc_cnt == OC_LAST)  w_nxt = ST_FAULT;
            else if (w_idle && r_idle_cnt == IDLE_LAST) w_nxt = ST_OFF;
         end
         ST_FAULT: begin
            if (r_cnt == COOL_LAST)
               w_nxt = (fuse_blown || r_retry >= RETRY_MAX) ? ST_LOCK : ST_OFF;
         end
         ST_LOCK: begin
            if (clr_fault && !fuse_blown) begin
               w_nxt       = ST_OFF;
               w_retry_clr = 1'b1;
            end
         end
         default:  w_nxt = ST_OFF;
      endcase
   end

   // A cycle that releases anything grants nothing; the freed budget is arbitrated next cycle.
   always_comb begin
      w_rel     = r_gnt & ~req;
      w_rel_sum = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_rel[i]) w_rel_sum = w_rel_sum + ALLOC_W'(r_lat[i]);
         w_elig[i] = (ALLOC_W'(req_ma[i]) + r_alloc) <= BUDGET_V;
      end
      w_arb_en = (r_state == ST_ON) && (w_nxt == ST_ON) && !(|w_rel);
      w_cand   = req & ~r_gnt & {NUM_REQ{w_arb_en}};
   end

   pwr_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .i_req   (w_cand),
      .i_elig  (w_elig),
      .i_ptr   (r_ptr),
      .o_pick  (w_pick)
   );

   always_comb begin
      w_pick_idx = '0;
      w_pick_amt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_pick[i]) begin
            w_pick_idx = PTR_W'(i);
            w_pick_amt = ALLOC_W'(req_ma[i]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_OFF;
         r_pwr_en   <= 1'b0;
         r_fault    <= 1'b0;
         r_lock     <= 1'b0;
         r_gnt      <= '0;
         r_alloc    <= '0;
         r_lat      <= '0;
         r_ptr      <= '0;
         r_cnt      <= '0;
         r_oc_cnt   <= '0;
         r_idle_cnt <= '0;
         r_retry    <= '0;
      end else begin
         r_state  <= w_nxt;
         r_pwr_en <= (w_nxt == ST_RAMP) || (w_nxt == ST_ON);
         r_fault  <= (w_nxt == ST_FAULT);
         r_lock   <= (w_nxt == ST_LOCK);

         r_cnt      <= (w_nxt != r_state) ? '0 : sat_inc(r_cnt);
         r_oc_cnt   <= (r_state == ST_ON && w_nxt == ST_ON && w_over) ? sat_inc(r_oc_cnt) : '0;
         r_idle_cnt <= (r_state == ST_ON && w_nxt == ST_ON && w_idle) ? sat_inc(r_idle_cnt) : '0;

         if (w_retry_clr)
            r_retry <= '0;
         else if (w_nxt == ST_FAULT && r_state != ST_FAULT && r_retry != RETRY_MAX)
            r_retry <= r_retry + RET_W'(1);

         if (w_nxt != ST_ON) begin
            r_gnt   <= '0;
            r_alloc <= '0;
         end else if (r_state == ST_ON) begin
            r_gnt   <= (r_gnt & ~w_rel) | w_pick;
            r_alloc <= r_alloc - w_rel_sum + w_pick_amt;
            if (|w_pick) begin
               r_lat[w_pick_idx] <= req_ma[w_pick_idx];
               r_ptr <= (w_pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + PTR_W'(1);
            end
         end
      end
   end

   assign pwr_en   = r_pwr_en;
   assign gnt      = r_gnt;
   assign alloc_ma = r_alloc;
   assign state    = r_state;
   assign fault    = r_fault;
   assign lockout  = r_lock;

endmodule

// File: tb/tb_pwr_load_sched.sv
// Directed vector bench for pwr_load_sched: a table of held-input steps plus timing sequences.
module tb_pwr_load_sched;
   import pwr_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [3:0]        req = '0;
   logic [3:0][9:0]   req_ma = '0;
   logic              powered = 1'b0;
   logic              fuse_blown = 1'b0;
   logic [9:0]        meas_ma = '0;
   logic              clr_fault = 1'b0;
   logic              pwr_en;
   logic [3:0]        gnt;
   logic [10:0]       alloc_ma;
   logic [2:0]        state;
   logic              fault;
   logic              lockout;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   pwr_load_sched dut (
      .clk(clk), .rst(rst), .req(req), .req_ma(req_ma), .powered(powered),
      .fuse_blown(fuse_blown), .meas_ma(meas_ma), .clr_fault(clr_fault),
      .pwr_en(pwr_en), .gnt(gnt), .alloc_ma(alloc_ma), .state(state),
      .fault(fault), .lockout(lockout)
   );

   typedef struct {
      logic            rst;
      logic [3:0]      req;
      logic [3:0][9:0] ma;
      logic            pw;
      logic            fuse;
      logic [9:0]      meas;
      logic            clr;
      int              n;
      logic [2:0]      st;
      logic            pen;
      logic [3:0]      gnt;
      logic [10:0]     alloc;
   } vec_t;

   vec_t tv[$];

   function automatic void add(input logic r, input logic [3:0] rq,
                               input int m0, input int m1, input int m2, input int m3,
                               input logic pw, input logic fu, input int meas, input logic clr,
                               input int n, input pwr_state_e st, input logic pen,
                               input logic [3:0] g, input int al);
      vec_t v;
      v.rst = r; v.req = rq;
      v.ma[0] = 10'(m0); v.ma[1] = 10'(m1); v.ma[2] = 10'(m2); v.ma[3] = 10'(m3);
      v.pw = pw; v.fuse = fu; v.meas = 10'(meas); v.clr = clr; v.n = n;
      v.st = st; v.pen = pen; v.gnt = g; v.alloc = 11'(al);
      tv.push_back(v);
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      logic ef, el;
      rst = v.rst; req = v.req; req_ma = v.ma; powered = v.pw;
      fuse_blown = v.fuse; meas_ma = v.meas; clr_fault = v.clr;
      repeat (v.n) @(posedge clk);
      #1;
      ef = (v.st == ST_FAULT);
      el = (v.st == ST_LOCK);
      nvec++;
      if (state !== v.st || pwr_en !== v.pen || gnt !== v.gnt || alloc_ma !== v.alloc ||
          fault !== ef || lockout !== el) begin
         nmis++;
         $display("FAIL vec%0d: got state=%0d pwr_en=%b gnt=%b alloc=%0d fault=%b lock=%b; want state=%0d pwr_en=%b gnt=%b alloc=%0d fault=%b lock=%b",
                  idx, state, pwr_en, gnt, alloc_ma, fault, lockout,
                  v.st, v.pen, v.gnt, v.alloc, ef, el);
      end
   endtask

   task automatic edges_until(input logic [2:0] target, input int limit, output int cnt);
      cnt = 0;
      while (state !== target && cnt < limit) begin
         @(posedge clk); #1;
         cnt++;
      end
   endtask

   task automatic chk_int(input string name, input int got, input int want);
      nvec++;
      if (got != want) begin
         nmis++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   initial begin
      int c;

      // power-up, single grant, latched amount, release, idle power-down
      add(1,4'b0000,   0,0,0,0, 0,0,0,0,  1, ST_OFF,  0,4'b0000,0);
      add(0,4'b0001, 120,0,0,0, 0,0,0,0,  1, ST_RAMP, 1,4'b0000,0);
      add(0,4'b0001, 120,0,0,0, 0,0,0,0,  5, ST_RAMP, 1,4'b0000,0);
      add(0,4'b0001, 120,0,0,0, 1,0,0,0, 10, ST_RAMP, 1,4'b0000,0);
      add(0,4'b0001, 120,0,0,0, 1,0,0,0,  1, ST_ON,   1,4'b0000,0);
      add(0,4'b0001, 120,0,0,0, 1,0,0,0,  1, ST_ON,   1,4'b0001,120);
      add(0,4'b0001, 300,0,0,0, 1,0,0,0,  2, ST_ON,   1,4'b0001,120);
      add(0,4'b0000, 300,0,0,0, 1,0,0,0,  1, ST_ON,   1,4'b0000,0);
      add(0,4'b0000,   0,0,0,0, 1,0,0,0, 30, ST_ON,   1,4'b0000,0);
      add(0,4'b0000,   0,0,0,0, 1,0,0,0,  1, ST_OFF,  0,4'b0000,0);
      add(0,4'b0000,   0,0,0,0, 1,0,0,1,  2, ST_OFF,  0,4'b0000,0);
      // budget-limited round robin, release, oversize requester, over-current
      add(1,4'b0000,   0,  0,  0,  0, 0,0,0,0,  1, ST_OFF,  0,4'b0000,0);
      add(0,4'b0111, 200,200,150,  0, 1,0,0,0,  1, ST_RAMP, 1,4'b0000,0);
      add(0,4'b0111, 200,200,150,  0, 1,0,0,0, 15, ST_RAMP, 1,4'b0000,0);
      add(0,4'b0111, 200,200,150,  0, 1,0,0,0,  1, ST_ON,   1,4'b0000,0);
      add(0,4'b0111, 200,200,150,  0, 1,0,0,0,  1, ST_ON,   1,4'b0001,200);
      add(0,4'b0111, 200,200,150,  0, 1,0,0,0,  1, ST_ON,   1,4'b0011,400);
      add(0,4'b0111, 200,200,150,  0, 1,0,0,0,  2, ST_ON,   1,4'b0011,400);
      add(0,4'b0110, 200,200,150,  0, 1,0,0,0,  1, ST_ON,   1,4'b0010,200);
      add(0,4'b0110, 200,200,150,  0, 1,0,0,0,  1, ST_ON,   1,4'b0110,350);
      add(0,4'b1110, 200,200,150,600, 1,0,0,0,  3, ST_ON,   1,4'b0110,350);
      add(0,4'b1111, 100,200,150,600, 1,0,0,0,  1, ST_ON,   1,4'b0111,450);
      add(0,4'b1111, 100,200,150,600, 1,0,600,0, 7, ST_ON,  1,4'b0111,450);
      add(0,4'b1111, 100,200,150,600, 1,0,400,0, 1, ST_ON,  1,4'b0111,450);
      add(0,4'b1111, 100,200,150,600, 1,0,600,0, 7, ST_ON,  1,4'b0111,450);
      add(0,4'b1111, 100,200,150,600, 1,0,600,0, 1, ST_FAULT,0,4'b0000,0);
      add(0,4'b0000,   0,  0,  0,  0, 1,0,0,1, 63, ST_FAULT,0,4'b0000,0);
      add(0,4'b0000,   0,  0,  0,  0, 1,0,0,0,  1, ST_OFF,  0,4'b0000,0);
      // fuse in ON -> FAULT -> LOCK; clear only honoured once fuse is good
      add(1,4'b0000,   0,0,0,0, 0,0,0,0,  1, ST_OFF,  0,4'b0000,0);
      add(0,4'b0001, 120,0,0,0, 1,0,0,0, 17, ST_ON,   1,4'b0000,0);
      add(0,4'b0001, 120,0,0,0, 1,0,0,0,  1, ST_ON,   1,4'b0001,120);
      add(0,4'b0001, 120,0,0,0, 1,1,0,0,  1, ST_FAULT,0,4'b0000,0);
      add(0,4'b0001, 120,0,0,0, 1,1,0,0, 63, ST_FAULT,0,4'b0000,0);
      add(0,4'b0001, 120,0,0,0, 1,1,0,0,  1, ST_LOCK, 0,4'b0000,0);
      add(0,4'b0001, 120,0,0,0, 1,1,0,1,  1, ST_LOCK, 0,4'b0000,0);
      add(0,4'b0001, 120,0,0,0, 1,1,0,0,  2, ST_LOCK, 0,4'b0000,0);
      add(0,4'b0001, 120,0,0,0, 1,0,0,1,  1, ST_OFF,  0,4'b0000,0);
      // three ramp failures lock out; clear restores the retry budget; reset mid-FAULT
      add(1,4'b0000, 0,0,0,0, 0,0,0,0,  1, ST_OFF,  0,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,0,  1, ST_RAMP, 1,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,0, 16, ST_FAULT,0,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,0, 64, ST_OFF,  0,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,0,  1, ST_RAMP, 1,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,0, 16, ST_FAULT,0,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,0, 64, ST_OFF,  0,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,0,  1, ST_RAMP, 1,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,0, 16, ST_FAULT,0,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,0, 64, ST_LOCK, 0,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,1,  1, ST_OFF,  0,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,0,  1, ST_RAMP, 1,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,0, 16, ST_FAULT,0,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,0, 64, ST_OFF,  0,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,0,  1, ST_RAMP, 1,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,0, 16, ST_FAULT,0,4'b0000,0);
      add(0,4'b0001, 0,0,0,0, 0,0,0,0, 10, ST_FAULT,0,4'b0000,0);
      add(1,4'b0000, 0,0,0,0, 0,0,0,0,  1, ST_OFF,  0,4'b0000,0);
      // reset mid-RAMP, oversize lone requester, fuse during RAMP
      add(0,4'b0001, 120,0,0,0, 1,0,0,0,  1, ST_RAMP, 1,4'b0000,0);
      add(0,4'b0001, 120,0,0,0, 1,0,0,0,  7, ST_RAMP, 1,4'b0000,0);
      add(1,4'b0001, 120,0,0,0, 1,0,0,0,  1, ST_OFF,  0,4'b0000,0);
      add(0,4'b0001, 600,0,0,0, 1,0,0,0,  1, ST_RAMP, 1,4'b0000,0);
      add(0,4'b0001, 600,0,0,0, 1,0,0,0, 16, ST_ON,   1,4'b0000,0);
      add(0,4'b0001, 600,0,0,0, 1,0,0,0,  5, ST_ON,   1,4'b0000,0);
      add(1,4'b0000,   0,0,0,0, 0,0,0,0,  1, ST_OFF,  0,4'b0000,0);
      add(0,4'b0001,   0,0,0,0, 1,0,0,0,  3, ST_RAMP, 1,4'b0000,0);
      add(0,4'b0001,   0,0,0,0, 1,1,0,0,  1, ST_FAULT,0,4'b0000,0);

      for (int i = 0; i < tv.size(); i++) run_vec(tv[i], i);

      // exact OFF->ON latency, then fuse reaction and cool-down length
      rst = 1'b1; req = '0; fuse_blown = 1'b0; clr_fault = 1'b0; meas_ma = '0;
      @(posedge clk); #1;
      rst = 1'b0; req = 4'b0001; req_ma = '0; req_ma[0] = 10'd120; powered = 1'b1;
      edges_until(ST_ON, 40, c);
      chk_int("off_to_on_edges", c, 17);
      fuse_blown = 1'b1;
      edges_until(ST_FAULT, 10, c);
      chk_int("fuse_to_fault_edges", c, 1);
      edges_until(ST_LOCK, 100, c);
      chk_int("fault_to_lock_edges", c, 64);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
